// File: rtl/window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_gen_pkg
// Purpose  : Shared defaults, pixel type and index helpers for the
//            streaming 2-D window generator.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package window_gen_pkg;

    localparam int c_DATA_W_DEFAULT   = 8;
    localparam int c_KERNEL_W_DEFAULT = 3;

    typedef logic [c_DATA_W_DEFAULT-1:0] pixel_t;

    // One spare line beyond the kernel height lets the writer fill the next
    // line while the reader is still sweeping the current window rows.
    function automatic int num_lines(input int k);
        return k + 1;
    endfunction

    // Bit offset of window element (r,c) in the flattened window vector.
    function automatic int win_idx(input int r, input int c, input int k, input int w);
        return (r * k + c) * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_gen_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : line_ram
// Purpose  : Simple dual-port line buffer, one write port and one read port
//            with a single-cycle registered read.
// Ports    : clk_i                - clock
//            wr_en_i/addr/data    - write port
//            rd_en_i/rd_addr_i    - read request
//            rd_data_o            - read data, valid the cycle after rd_en_i
// Revision : 1.0 - initial release
// ============================================================================
module line_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // No reset on the storage array so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
// Module   : window_gen
// Purpose  : Streaming KERNEL_W x KERNEL_W window generator. Buffers raster
//            lines in a rotating set of KERNEL_W+1 line RAMs and emits one
//            valid-region window per cycle once KERNEL_W lines are stored.
// Ports    : clk_i, srst_n_i (sync, active-low)
//            pixel_data_i / pixel_data_valid_i / pixel_ready_o - input stream
//            window_o / window_valid_o                         - window out
//            line_done_o - pulse with the last window of a retired line
// Revision : 1.0 - initial release
// ============================================================================
module window_gen
    import window_gen_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int KERNEL_W = c_KERNEL_W_DEFAULT,
    parameter int IMG_W    = 512
) (
    input  logic                                clk_i,
    input  logic                                srst_n_i,
    input  logic [DATA_W-1:0]                   pixel_data_i,
    input  logic                                pixel_data_valid_i,
    output logic                                pixel_ready_o,
    output logic [KERNEL_W*KERNEL_W*DATA_W-1:0] window_o,
    output logic                                window_valid_o,
    output logic                                line_done_o
);

    localparam int c_NUM_LINES = num_lines(KERNEL_W);
    localparam int c_LINE_W    = $clog2(c_NUM_LINES);
    localparam int c_COL_W     = $clog2(IMG_W);
    localparam int c_CNT_W     = $clog2(c_NUM_LINES + 1);

    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(IMG_W - 1);
    localparam logic [c_COL_W-1:0] c_FIRST_WIN_COL = c_COL_W'(KERNEL_W - 1);
    localparam logic [c_CNT_W-1:0] c_KW_CNT   = c_CNT_W'(KERNEL_W);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(c_NUM_LINES);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Line index arithmetic modulo the number of line RAMs.
    function automatic logic [c_LINE_W-1:0] line_add(input logic [c_LINE_W-1:0] base,
                                                     input int off);
        int s;
        s = int'(base) + off;
        if (s >= c_NUM_LINES) begin
            s = s - c_NUM_LINES;
        end
        return c_LINE_W'(s);
    endfunction

    logic [0:0]          r_state;
    logic [c_COL_W-1:0]  r_wr_col;
    logic [c_LINE_W-1:0] r_wr_line;
    logic [c_COL_W-1:0]  r_rd_col;
    logic [c_LINE_W-1:0] r_rd_line;
    logic [c_CNT_W-1:0]  r_lines_full;

    // Stage 1: read issued last cycle, RAM data now on the read ports.
    logic                r_s1_pend;
    logic                r_s1_win;
    logic                r_s1_last;
    logic [c_LINE_W-1:0] r_s1_line;

    logic [KERNEL_W*KERNEL_W*DATA_W-1:0] r_window;
    logic                                r_window_valid;
    logic                                r_line_done;

    logic                w_accept;
    logic                w_wr_wrap;
    logic                w_rd_issue;
    logic                w_rd_last;
    logic [c_CNT_W-1:0]  w_lines_full_nxt;
    logic [DATA_W-1:0]   w_ram_q  [c_NUM_LINES];
    logic [DATA_W-1:0]   w_col_in [KERNEL_W];

    assign pixel_ready_o = (r_lines_full != c_FULL_CNT);
    assign w_accept      = pixel_data_valid_i && pixel_ready_o;
    assign w_wr_wrap     = w_accept && (r_wr_col == c_LAST_COL);
    assign w_rd_issue    = (r_state == c_ST_RUN);
    assign w_rd_last     = w_rd_issue && (r_rd_col == c_LAST_COL);

    // A line completing in the same cycle another retires leaves the count as is.
    always_comb begin
        w_lines_full_nxt = r_lines_full;
        if (w_wr_wrap && !w_rd_last) begin
            w_lines_full_nxt = r_lines_full + c_CNT_W'(1);
        end else if (!w_wr_wrap && w_rd_last) begin
            w_lines_full_nxt = r_lines_full - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_wr_col     <= '0;
            r_wr_line    <= '0;
            r_lines_full <= '0;
        end else begin
            r_lines_full <= w_lines_full_nxt;
            if (w_accept) begin
                if (w_wr_wrap) begin
                    r_wr_col  <= '0;
                    r_wr_line <= line_add(r_wr_line, 1);
                end else begin
                    r_wr_col <= r_wr_col + c_COL_W'(1);
                end
            end
        end
    end

    // Read sweep. The retiring line's last column is read at the same edge the
    // count drops, so the writer can only reuse that RAM from the next cycle.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state   <= c_ST_IDLE;
            r_rd_col  <= '0;
            r_rd_line <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_rd_col <= '0;
                    if (r_lines_full >= c_KW_CNT) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_rd_last) begin
                        r_rd_col  <= '0;
                        r_rd_line <= line_add(r_rd_line, 1);
                        if (w_lines_full_nxt < c_KW_CNT) begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_rd_col <= r_rd_col + c_COL_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < c_NUM_LINES; gi++) begin : g_line
        line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_line_ram (
            .clk_i     (clk_i),
            .wr_en_i   (w_accept && (r_wr_line == c_LINE_W'(gi))),
            .wr_addr_i (r_wr_col),
            .wr_data_i (pixel_data_i),
            .rd_en_i   (w_rd_issue),
            .rd_addr_i (r_rd_col),
            .rd_data_o (w_ram_q[gi])
        );
    end

    // Row r of the window comes from the line rd_line+r captured at issue time,
    // since rd_line may already have advanced when the data returns.
    always_comb begin
        w_col_in = '{default: '0};
        for (int r = 0; r < KERNEL_W; r++) begin
            w_col_in[r] = w_ram_q[line_add(r_s1_line, r)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_s1_pend      <= 1'b0;
            r_s1_win       <= 1'b0;
            r_s1_last      <= 1'b0;
            r_s1_line      <= '0;
            r_window_valid <= 1'b0;
            r_line_done    <= 1'b0;
        end else begin
            r_s1_pend      <= w_rd_issue;
            r_s1_win       <= w_rd_issue && (r_rd_col >= c_FIRST_WIN_COL);
            r_s1_last      <= w_rd_last;
            r_s1_line      <= r_rd_line;
            r_window_valid <= r_s1_win;
            r_line_done    <= r_s1_last;
        end
    end

    // Column shift register: newest column enters at c=KERNEL_W-1. It is only
    // cleared in IDLE once the final read of a line has drained through.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_window <= '0;
        end else if (r_s1_pend) begin
            for (int r = 0; r < KERNEL_W; r++) begin
                for (int c = 0; c < KERNEL_W - 1; c++) begin
                    r_window[win_idx(r, c, KERNEL_W, DATA_W) +: DATA_W] <=
                        r_window[win_idx(r, c + 1, KERNEL_W, DATA_W) +: DATA_W];
                end
                r_window[win_idx(r, KERNEL_W - 1, KERNEL_W, DATA_W) +: DATA_W] <= w_col_in[r];
            end
        end else if (r_state == c_ST_IDLE) begin
            r_window <= '0;
        end
    end

    assign window_o       = r_window;
    assign window_valid_o = r_window_valid;
    assign line_done_o    = r_line_done;

endmodule
`default_nettype wire
